// File: rtl/convolver_complex.sv
// Pipelined fixed-point KxK convolution window: multiply, sum, then shift, add bias and saturate.
// A write at edge N produces conv_final_result and a one-cycle enable_signal after edge N+3.
module convolver_complex #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned FRAC_BIT    = 8,
  parameter int unsigned IMAGE_SIZE  = 28
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              write,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     weights_matrix,
  input  logic [DATA_WIDTH-1:0]                             bias,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     pixel_in,
  output logic [DATA_WIDTH-1:0]                             conv_final_result,
  output logic                                              enable_signal
);

  localparam int unsigned K2     = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned ACC_W  = PROD_W + $clog2(K2);
  localparam int unsigned EXT_W  = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'd1 << (DATA_WIDTH - 1)) - 64'd1);
  localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

  // The image edge only frames the feature map; a kernel larger than it is a configuration error.
  if (IMAGE_SIZE < KERNEL_SIZE) begin : g_bad_cfg
    $error("convolver_complex: KERNEL_SIZE exceeds IMAGE_SIZE");
  end

  logic signed [PROD_W-1:0]     prod_d [K2];
  logic signed [PROD_W-1:0]     prod_q [K2];
  logic signed [DATA_WIDTH-1:0] bias1_q;
  logic signed [DATA_WIDTH-1:0] bias2_q;
  logic signed [ACC_W-1:0]      sum_d;
  logic signed [ACC_W-1:0]      sum_q;
  logic signed [ACC_W-1:0]      shift_d;
  logic signed [EXT_W-1:0]      biased_d;
  logic        [DATA_WIDTH-1:0] sat_d;
  logic        [DATA_WIDTH-1:0] sat_q;
  logic        [DATA_WIDTH-1:0] conv_q;
  logic        [2:0]            valid_q;
  logic                         en_q;

  // Stage 1: full-precision tap products.
  always_comb begin
    for (int unsigned i = 0; i < K2; i++) begin
      prod_d[i] = PROD_W'(signed'(pixel_in[i*DATA_WIDTH +: DATA_WIDTH]))
                * PROD_W'(signed'(weights_matrix[i*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Stage 2: accumulator is wide enough that K2 worst-case products cannot overflow.
  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < K2; i++) begin
      sum_d = sum_d + ACC_W'(prod_q[i]);
    end
  end

  // Stage 3: rescale, add bias at full width, then clamp once.
  always_comb begin
    shift_d  = sum_q >>> FRAC_BIT;
    biased_d = EXT_W'(shift_d) + EXT_W'(bias2_q);
    sat_d    = biased_d[DATA_WIDTH-1:0];
    if (biased_d > SAT_MAX) begin
      sat_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (biased_d < SAT_MIN) begin
      sat_d = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

  // Each stage only loads when its valid bit says a window is arriving, so idle slots hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < K2; i++) begin
        prod_q[i] <= '0;
      end
      bias1_q <= '0;
      bias2_q <= '0;
      sum_q   <= '0;
      sat_q   <= '0;
      conv_q  <= '0;
      valid_q <= '0;
      en_q    <= 1'b0;
    end else begin
      valid_q <= {valid_q[1:0], write};
      en_q    <= valid_q[2];
      if (write) begin
        prod_q  <= prod_d;
        bias1_q <= bias;
      end
      if (valid_q[0]) begin
        sum_q   <= sum_d;
        bias2_q <= bias1_q;
      end
      if (valid_q[1]) begin
        sat_q <= sat_d;
      end
      if (valid_q[2]) begin
        conv_q <= sat_q;
      end
    end
  end

  assign conv_final_result = conv_q;
  assign enable_signal     = en_q;

endmodule

// File: tb/tb_convolver_complex.sv
// Scoreboard bench for convolver_complex: expected results are queued at drive time
// and compared, with their arrival cycle, whenever enable_signal pulses.
module tb_convolver_complex;

  localparam int unsigned W   = 16;
  localparam int unsigned KS  = 5;
  localparam int unsigned K2  = KS * KS;
  localparam int unsigned KW  = K2 * W;
  localparam int unsigned FB  = 8;

  typedef struct {
    logic signed [63:0] val;
    longint             due;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          write;
  logic [KW-1:0] wts;
  logic [W-1:0]  bias;
  logic [KW-1:0] pix;
  logic [W-1:0]  conv_final_result;
  logic          enable_signal;

  logic signed [63:0] res_s;
  logic signed [63:0] last_exp;
  exp_t               sb_q[$];
  longint             cyc;
  int                 n_chk;
  int                 n_err;
  bit                 mon_on;

  convolver_complex #(
    .DATA_WIDTH (W),
    .KERNEL_SIZE(KS),
    .FRAC_BIT   (FB),
    .IMAGE_SIZE (28)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .write            (write),
    .weights_matrix   (wts),
    .bias             (bias),
    .pixel_in         (pix),
    .conv_final_result(conv_final_result),
    .enable_signal    (enable_signal)
  );

  assign res_s = 64'(signed'(conv_final_result));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic signed [63:0] model(input logic [KW-1:0] p, input logic [KW-1:0] w,
                                               input logic [W-1:0] b);
    longint acc;
    logic [W-1:0] pv;
    logic [W-1:0] wv;
    acc = 0;
    for (int i = 0; i < int'(K2); i++) begin
      pv  = p[i*W +: W];
      wv  = w[i*W +: W];
      acc = acc + longint'(signed'(pv)) * longint'(signed'(wv));
    end
    acc = acc >>> FB;
    acc = acc + longint'(signed'(b));
    if (acc > 32767)  acc = 32767;
    if (acc < -32768) acc = -32768;
    return 64'(acc);
  endfunction

  // One write per call; consecutive calls keep write high for back-to-back windows.
  task automatic send(input logic [KW-1:0] p, input logic [KW-1:0] w, input logic [W-1:0] b,
                      input logic signed [63:0] e);
    exp_t item;
    @(negedge clk);
    pix   = p;
    wts   = w;
    bias  = b;
    write = 1'b1;
    item.val = e;
    item.due = cyc + 4;
    sb_q.push_back(item);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      write = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_on && !reset) begin
      if (enable_signal === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("spurious_enable", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("result", res_s, e.val);
          chk("latency", 64'(cyc), 64'(e.due));
          last_exp = e.val;
        end
      end else begin
        chk("enable_low", 64'(enable_signal), 64'd0);
        chk("hold", res_s, last_exp);
      end
    end
  end

  initial begin
    logic [KW-1:0] p;
    logic [KW-1:0] w;
    logic [W-1:0]  b;
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    mon_on   = 1'b0;
    last_exp = 0;
    write    = 1'b0;
    pix      = '0;
    wts      = '0;
    bias     = '0;
    reset    = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("reset_result", res_s, 64'd0);
    chk("reset_enable", 64'(enable_signal), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    mon_on = 1'b1;

    // All ones at 1.0 -> 25.0
    for (int i = 0; i < int'(K2); i++) begin
      p[i*W +: W] = 16'd256;
      w[i*W +: W] = 16'd256;
    end
    send(p, w, 16'd0, 64'sd6400);
    idle(1);
    drain();

    // Single tap with bias: 2.0 * -1.5 + 0.5 = -2.5
    p = '0;
    w = '0;
    p[0 +: W] = 16'd512;
    w[0 +: W] = 16'hFE80;
    send(p, w, 16'd128, -64'sd640);
    idle(1);
    drain();

    // Positive and negative saturation
    for (int i = 0; i < int'(K2); i++) begin
      p[i*W +: W] = 16'h7FFF;
      w[i*W +: W] = 16'h7FFF;
    end
    send(p, w, 16'd0, 64'sd32767);
    for (int i = 0; i < int'(K2); i++) w[i*W +: W] = 16'h8000;
    send(p, w, 16'd0, -64'sd32768);
    idle(1);
    drain();

    // Five back-to-back writes, bias only
    for (int k = 0; k < 5; k++) send('0, '0, W'(k), 64'(k));
    idle(1);
    drain();

    // Random back-to-back windows; small weights keep some results unsaturated
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < int'(K2); i++) begin
        p[i*W +: W] = W'($urandom);
        w[i*W +: W] = (k < 5) ? W'($urandom_range(0, 127) - 64) : W'($urandom);
      end
      b = W'($urandom);
      send(p, w, b, model(p, w, b));
    end
    idle(1);
    drain();

    // Single write then changing inputs with write low: exactly one result, then hold
    p = '0;
    w = '0;
    p[3*W +: W] = 16'd1000;
    w[3*W +: W] = 16'd300;
    send(p, w, 16'hFFF0, model(p, w, 16'hFFF0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      write = 1'b0;
      pix   = {KW/32{$urandom}};
      wts   = {KW/32{$urandom}};
      bias  = W'($urandom);
    end
    drain();

    // Mid-run reset with two windows in flight: output clears at once, no pulses follow
    @(negedge clk);
    pix   = {K2{16'd256}};
    wts   = {K2{16'd256}};
    bias  = 16'd7;
    write = 1'b1;
    @(negedge clk);
    bias  = 16'd9;
    @(negedge clk);
    write = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_result", res_s, 64'd0);
    chk("midrst_enable", 64'(enable_signal), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    last_exp = 0;
    idle(5);

    // First write after reset keeps the normal latency
    send({K2{16'd256}}, {K2{16'd128}}, 16'd3, 64'sd3203);
    idle(1);
    drain();
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/convolver_complex.md
CONVOLVER_COMPLEX -- requirements
Module: convolver_complex

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of every pixel, weight, bias and result word (signed two's complement).
REQ-002 SHALL have parameter KERNEL_SIZE, default 5: kernel edge length, giving K2 = KERNEL_SIZE**2 taps.
REQ-003 SHALL have parameter FRAC_BIT, default 8: number of fractional bits in all fixed-point operands and in the result.
REQ-004 SHALL have parameter IMAGE_SIZE, default 28: image edge length; carried for the feature-map context and has no effect on the arithmetic.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port write, input, 1 bit: when high at a rising edge, the current pixel_in, weights_matrix and bias are accepted as one new window.
REQ-009 SHALL have port weights_matrix, input, K2*DATA_WIDTH bits: tap i at bits [i*DATA_WIDTH +: DATA_WIDTH], where i = row*KERNEL_SIZE + col.
REQ-010 SHALL have port bias, input, DATA_WIDTH bits: signed bias in the same Q format.
REQ-011 SHALL have port pixel_in, input, K2*DATA_WIDTH bits: window pixel i, packed the same way as weights_matrix.
REQ-012 SHALL have port conv_final_result, output, DATA_WIDTH bits: registered, saturated convolution result.
REQ-013 SHALL have port enable_signal, output, 1 bit: registered; high for exactly one cycle for each new conv_final_result.

Function
REQ-014 Stage 1 SHALL register the K2 full-precision signed products pixel_i*weight_i, each 2*DATA_WIDTH bits, together with the bias, on every edge where write=1.
REQ-015 Stage 2 SHALL register the signed sum of all K2 products in an accumulator of 2*DATA_WIDTH+ceil(log2(K2)) bits (37 bits at defaults), with no overflow possible.
REQ-016 Stage 3 SHALL arithmetic-shift the sum right by FRAC_BIT (truncation toward minus infinity), add the sign-extended bias, and saturate the result.
REQ-017 Saturation SHALL clamp to +(2**(DATA_WIDTH-1))-1 and -(2**(DATA_WIDTH-1)); the result is then registered into conv_final_result.
REQ-018 Latency SHALL be exactly 3 cycles: write sampled at edge N gives conv_final_result and enable_signal=1 valid after edge N+3.
REQ-019 A valid bit SHALL travel through a 3-deep shift register in step with the data; enable_signal is the valid bit of stage 3.
REQ-020 The pipeline SHALL be fully pipelined, accepting one window per cycle; back-to-back writes give back-to-back results in order.
REQ-021 When write=0, stage data SHALL hold and conv_final_result SHALL keep its last value; enable_signal=0 for the corresponding slots.
REQ-022 Changes to weights_matrix, bias or pixel_in between writes SHALL NOT affect windows already accepted.
REQ-023 Saturation SHALL apply only after the bias is added, never to intermediate sums.

Reset
REQ-024 While reset=1, all pipeline registers, valid bits, conv_final_result and enable_signal SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-025 Windows in flight when reset is asserted SHALL be discarded and never produce enable_signal.
REQ-026 After reset is deasserted, the first write SHALL give its result with the normal 3-cycle latency.

Verification
REQ-027 Assert reset mid-run -> conv_final_result=0 and enable_signal=0 immediately; no pulse appears for discarded windows.
REQ-028 All 25 pixels=256 (1.0), all weights=256, bias=0, one write -> 3 cycles later enable_signal=1 for one cycle, result=6400 (25.0).
REQ-029 pixel[0]=512 (2.0), weight[0]=-384 (-1.5), all other taps 0, bias=128 (0.5) -> result=-640 (-2.5).
REQ-030 All pixels=32767, all weights=32767 -> result=32767; the same with all weights=-32768 -> result=-32768.
REQ-031 Five consecutive writes with bias 0,1,2,3,4 and all other inputs 0 -> enable_signal high for 5 consecutive cycles, results 0,1,2,3,4 in order.
REQ-032 A single write followed by changed inputs with write=0 -> exactly one result, equal to the value for the sampled window; the output then holds.
